// File: rtl/hash_mem_pkg.sv
// Shared types and constants for the hasher memory responder.
package hash_mem_pkg;

    localparam int ADDR_W         = 16;
    localparam int DATA_W         = 32;
    localparam int NUM_NONCES_DEF = 16;

    typedef enum logic {
        C_IDLE,
        C_ACTIVE
    } core_state_t;

    typedef enum logic [1:0] {
        H_IDLE,
        H_RD,
        H_RSP
    } host_state_t;

    // Host-side request as seen by the array mux
    typedef struct packed {
        logic              we;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
    } host_req_t;

    // True when a word address falls inside the physical array
    function automatic logic in_range(input logic [ADDR_W-1:0] addr, input int unsigned depth);
        return 32'(addr) < depth;
    endfunction

endpackage

// File: rtl/hash_mem_array.sv
// Single-write / single-read word array with a registered read port.
// Contents are deliberately not reset; only the output register is.
module hash_mem_array #(
    parameter int DEPTH  = 256,
    parameter int DATA_W = 32,
    parameter int AW     = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              we,
    input  logic [AW-1:0]     waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              re,
    input  logic [AW-1:0]     raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [DEPTH];

    // Storage write
    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    // Registered read; holds its value when no read is requested
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)  rdata <= '0;
        else if (re)   rdata <= mem[raddr];
    end

endmodule

// File: rtl/hash_mem_responder.sv
// Memory responder on the far side of the hasher's memory port.
// The core owns the array from core_start until core_done; otherwise a
// valid/ready host port may read/write it. Tracks writes into the result
// window and flags results_valid once the window is full and the core is done.
// Optional build macro: HASH_MEM_OOR_TRAP_EN (sticky out-of-range flag).
module hash_mem_responder
    import hash_mem_pkg::*;
#(
    parameter int DEPTH      = 256,
    parameter int NUM_NONCES = NUM_NONCES_DEF
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              core_start,
    input  logic              core_done,
    input  logic              mem_we,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_write_data,
    output logic [DATA_W-1:0] mem_read_data,
    input  logic              host_req_valid,
    output logic              host_req_ready,
    input  logic              host_req_we,
    input  logic [ADDR_W-1:0] host_req_addr,
    input  logic [DATA_W-1:0] host_req_wdata,
    output logic              host_rsp_valid,
    output logic [DATA_W-1:0] host_rsp_data,
    input  logic              host_rsp_ready,
    input  logic [ADDR_W-1:0] out_base,
    output logic              results_valid,
    output logic [7:0]        result_count,
    output logic              oor_err
);

    localparam int                AW   = $clog2(DEPTH);
    localparam logic [ADDR_W-1:0] NN_A = ADDR_W'(NUM_NONCES);
    localparam logic [7:0]        NN_C = 8'(NUM_NONCES);

    core_state_t       c_state, c_next;
    host_state_t       h_state, h_next;
    host_req_t         hreq;
    logic              owned;
    logic              rdy_en;
    logic              host_acc;
    logic              core_in_rng, host_in_rng;

    logic              arr_we, arr_re;
    logic [AW-1:0]     arr_waddr, arr_raddr;
    logic [DATA_W-1:0] arr_wdata, arr_rdata, arr_rdata_z;
    logic              rd_in_rng;
    logic              rd_oor_q, rd_core_q;
    logic [DATA_W-1:0] mem_rd_hold;

    logic [ADDR_W-1:0] win_base, win_base_sel, win_off;
    logic              win_hit;
    logic [7:0]        cnt_base, cnt_nxt;

    assign hreq        = '{we: host_req_we, addr: host_req_addr, wdata: host_req_wdata};
    assign core_in_rng = in_range(mem_addr, DEPTH);
    assign host_in_rng = in_range(hreq.addr, DEPTH);
    assign host_acc    = host_req_valid && host_req_ready;

    // ---------------- core FSM ----------------

    // Core state register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) c_state <= C_IDLE;
        else          c_state <= c_next;
    end

    // Core next state; a start in C_ACTIVE wins over a simultaneous done
    always_comb begin
        c_next = c_state;
        case (c_state)
            C_IDLE:   if (core_start) c_next = C_ACTIVE;
            C_ACTIVE: if (!core_start && core_done) c_next = C_IDLE;
            default:  c_next = C_IDLE;
        endcase
    end

    // Core owns the array in the start cycle and throughout C_ACTIVE
    always_comb begin
        owned = core_start || (c_state == C_ACTIVE);
    end

    // ---------------- host FSM ----------------

    // Ready is held off for the first edge after reset so it reads 0 in reset
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) rdy_en <= 1'b0;
        else          rdy_en <= 1'b1;
    end

    // Host state register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) h_state <= H_IDLE;
        else          h_state <= h_next;
    end

    // Host next state
    always_comb begin
        h_next = h_state;
        case (h_state)
            H_IDLE:  if (host_acc) h_next = hreq.we ? H_RSP : H_RD;
            H_RD:    h_next = H_RSP;
            H_RSP:   if (host_rsp_ready) h_next = H_IDLE;
            default: h_next = H_IDLE;
        endcase
    end

    // Host handshake outputs
    always_comb begin
        host_req_ready = rdy_en && (h_state == H_IDLE) && (c_state == C_IDLE) && !core_start;
        host_rsp_valid = (h_state == H_RSP);
    end

    // Private response register: only loaded from H_RD or on a write ack,
    // so core traffic during H_RD/H_RSP cannot disturb it
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)                     host_rsp_data <= '0;
        else if (host_acc && hreq.we)     host_rsp_data <= '0;
        else if (h_state == H_RD)         host_rsp_data <= arr_rdata_z;
    end

    // ---------------- array and port mux ----------------

    // Ownership mux; host access only happens while the core does not own the array
    always_comb begin
        arr_we    = 1'b0;
        arr_re    = 1'b0;
        arr_waddr = '0;
        arr_raddr = '0;
        arr_wdata = '0;
        rd_in_rng = 1'b1;
        if (owned) begin
            arr_re    = 1'b1;
            arr_raddr = mem_addr[AW-1:0];
            arr_we    = mem_we && core_in_rng;
            arr_waddr = mem_addr[AW-1:0];
            arr_wdata = mem_write_data;
            rd_in_rng = core_in_rng;
        end else if (host_acc) begin
            arr_re    = !hreq.we;
            arr_raddr = hreq.addr[AW-1:0];
            arr_we    = hreq.we && host_in_rng;
            arr_waddr = hreq.addr[AW-1:0];
            arr_wdata = hreq.wdata;
            rd_in_rng = host_in_rng;
        end
    end

    hash_mem_array #(
        .DEPTH  (DEPTH),
        .DATA_W (DATA_W),
        .AW     (AW)
    ) u_array (
        .clk     (clk),
        .reset_n (reset_n),
        .we      (arr_we),
        .waddr   (arr_waddr),
        .wdata   (arr_wdata),
        .re      (arr_re),
        .raddr   (arr_raddr),
        .rdata   (arr_rdata)
    );

    // Remember who issued the last read and whether it was out of range
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_core_q <= 1'b0;
            rd_oor_q  <= 1'b0;
        end else begin
            rd_core_q <= owned;
            if (arr_re) rd_oor_q <= !rd_in_rng;
        end
    end

    assign arr_rdata_z = rd_oor_q ? '0 : arr_rdata;

    // Core read data follows the array after an owned cycle, else holds
    assign mem_read_data = rd_core_q ? arr_rdata_z : mem_rd_hold;

    // Hold register so host reads never show up on the core read bus
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) mem_rd_hold <= '0;
        else          mem_rd_hold <= mem_read_data;
    end

    // ---------------- result window ----------------

    // Window hit test uses the incoming base in the start cycle itself
    always_comb begin
        win_base_sel = core_start ? out_base : win_base;
        win_off      = mem_addr - win_base_sel;
        win_hit      = owned && mem_we && (win_off < NN_A);
        cnt_base     = core_start ? 8'd0 : result_count;
        cnt_nxt      = (win_hit && (cnt_base < NN_C)) ? cnt_base + 8'd1 : cnt_base;
    end

    // Window base latch and saturating write counter
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            win_base     <= '0;
            result_count <= '0;
        end else begin
            if (core_start) win_base <= out_base;
            result_count <= cnt_nxt;
        end
    end

    // results_valid rises the cycle after core_done with a full window
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            results_valid <= 1'b0;
        else if (core_start)
            results_valid <= 1'b0;
        else if ((c_state == C_ACTIVE) && core_done && (cnt_nxt == NN_C))
            results_valid <= 1'b1;
    end

    // ---------------- out-of-range trap ----------------
`ifdef HASH_MEM_OOR_TRAP_EN
    logic              oor_hit;
    logic              oor_q;
    logic [ADDR_W-1:0] oor_addr_q;

    // Any owned core cycle drives a read, so it counts as an access
    always_comb begin
        oor_hit = (owned && !core_in_rng) || (host_acc && !host_in_rng);
    end

    // Sticky flag plus last offending address for debug
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            oor_q      <= 1'b0;
            oor_addr_q <= '0;
        end else begin
            if (core_start)   oor_q <= oor_hit;
            else if (oor_hit) oor_q <= 1'b1;
            if (oor_hit)      oor_addr_q <= owned ? mem_addr : hreq.addr;
        end
    end

    assign oor_err = oor_q;
`else
    assign oor_err = 1'b0;
`endif

endmodule

// File: tb/tb_hash_mem_responder.sv
// Scoreboard bench for hash_mem_responder: host responses are predicted at
// accept time and compared on the response handshake; core-side values are
// checked directly against constants derived from the stimulus.
module tb_hash_mem_responder;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        core_start = 1'b0, core_done = 1'b0;
    logic        mem_we = 1'b0;
    logic [15:0] mem_addr = '0;
    logic [31:0] mem_write_data = '0;
    logic [31:0] mem_read_data;
    logic        host_req_valid = 1'b0, host_req_ready, host_req_we = 1'b0;
    logic [15:0] host_req_addr = '0;
    logic [31:0] host_req_wdata = '0;
    logic        host_rsp_valid;
    logic [31:0] host_rsp_data;
    logic        host_rsp_ready = 1'b0;
    logic [15:0] out_base = '0;
    logic        results_valid;
    logic [7:0]  result_count;
    logic        oor_err;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] exp_q[$];

    hash_mem_responder dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .core_start     (core_start),
        .core_done      (core_done),
        .mem_we         (mem_we),
        .mem_addr       (mem_addr),
        .mem_write_data (mem_write_data),
        .mem_read_data  (mem_read_data),
        .host_req_valid (host_req_valid),
        .host_req_ready (host_req_ready),
        .host_req_we    (host_req_we),
        .host_req_addr  (host_req_addr),
        .host_req_wdata (host_req_wdata),
        .host_rsp_valid (host_rsp_valid),
        .host_rsp_data  (host_rsp_data),
        .host_rsp_ready (host_rsp_ready),
        .out_base       (out_base),
        .results_valid  (results_valid),
        .result_count   (result_count),
        .oor_err        (oor_err)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h exp %h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_rdy"},   32'(host_req_ready), 0);
        chk({tag, "_rspv"},  32'(host_rsp_valid), 0);
        chk({tag, "_rspd"},  host_rsp_data,       0);
        chk({tag, "_mrd"},   mem_read_data,       0);
        chk({tag, "_rv"},    32'(results_valid),  0);
        chk({tag, "_cnt"},   32'(result_count),   0);
        chk({tag, "_oor"},   32'(oor_err),        0);
    endtask

    // Present a request, wait for acceptance, predict the response
    task automatic host_issue(input logic we, input logic [15:0] addr,
                              input logic [31:0] wd, input logic [31:0] exp_rd,
                              input string tag);
        int n;
        host_req_valid = 1'b1;
        host_req_we    = we;
        host_req_addr  = addr;
        host_req_wdata = wd;
        n = 0;
        @(negedge clk);
        while (!host_req_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_acc"}, 32'(host_req_ready), 1);
        exp_q.push_back(we ? 32'h0 : exp_rd);
        tick();
        host_req_valid = 1'b0;
    endtask

    // Wait for a response and check its latency from the accept cycle
    task automatic host_wait(input string tag, input int exp_lat);
        int lat;
        lat = 1;
        @(negedge clk);
        while (!host_rsp_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        chk({tag, "_lat"}, 32'(lat), 32'(exp_lat));
    endtask

    // Compare the held response with the scoreboard head and consume it
    task automatic host_pop(input string tag);
        logic [31:0] e;
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hBAD0_BAD0;
        chk({tag, "_data"}, host_rsp_data, e);
        host_rsp_ready = 1'b1;
        tick();
        host_rsp_ready = 1'b0;
    endtask

    task automatic host_xfer(input logic we, input logic [15:0] addr,
                             input logic [31:0] wd, input logic [31:0] exp_rd,
                             input string tag);
        host_issue(we, addr, wd, exp_rd, tag);
        host_wait(tag, we ? 1 : 2);
        host_pop(tag);
    endtask

    initial begin
        // ---- reset state ----
        #2;
        chk_all_zero("reset");
        tick();
        tick();
        reset_n = 1'b1;
        tick();

        // ---- host preload and readback ----
        for (int i = 0; i < 19; i++)
            host_xfer(1'b1, 16'(i), 32'h1000 + 32'(i), 32'h0, $sformatf("pre_wr%0d", i));
        for (int i = 0; i < 19; i++)
            host_xfer(1'b0, 16'(i), 32'h0, 32'h1000 + 32'(i), $sformatf("pre_rd%0d", i));

        // ---- core read stream with host held off ----
        core_start     = 1'b1;
        mem_addr       = 16'd0;
        host_req_valid = 1'b1;
        host_req_we    = 1'b0;
        host_req_addr  = 16'd5;
        @(negedge clk);
        chk("cont_rdy_start", 32'(host_req_ready), 0);
        tick();
        core_start = 1'b0;
        mem_addr   = 16'd1;
        @(negedge clk);
        chk("core_rd0", mem_read_data, 32'h1000);
        chk("cont_rdy_act", 32'(host_req_ready), 0);
        tick();
        mem_addr = 16'd2;
        @(negedge clk);
        chk("core_rd1", mem_read_data, 32'h1001);
        tick();
        core_done = 1'b1;
        @(negedge clk);
        chk("core_rd2", mem_read_data, 32'h1002);
        chk("cont_rdy_done", 32'(host_req_ready), 0);
        tick();
        core_done = 1'b0;
        mem_addr  = 16'd0;
        @(negedge clk);
        chk("cont_rdy_after", 32'(host_req_ready), 1);
        exp_q.push_back(32'h1005);
        tick();
        host_req_valid = 1'b0;
        host_wait("cont_rd", 2);
        chk("core_rd_hold", mem_read_data, 32'h1002);
        host_pop("cont_rd");

        // ---- full result window with one saturating extra write ----
        out_base   = 16'h0080;
        core_start = 1'b1;
        tick();
        core_start = 1'b0;
        for (int i = 0; i < 17; i++) begin
            mem_we         = 1'b1;
            mem_addr       = (i < 16) ? 16'h0080 + 16'(i) : 16'h0085;
            mem_write_data = (i < 16) ? 32'hA000 + 32'(i) : 32'hBEEF;
            @(negedge clk);
            if (i == 8) chk("win_cnt_mid", 32'(result_count), 8);
            tick();
        end
        mem_we = 1'b0;
        @(negedge clk);
        chk("win_cnt_sat", 32'(result_count), 16);
        tick();
        core_done = 1'b1;
        @(negedge clk);
        chk("win_rv_done", 32'(results_valid), 0);
        tick();
        core_done = 1'b0;
        @(negedge clk);
        chk("win_rv_after", 32'(results_valid), 1);
        tick();
        host_xfer(1'b0, 16'h0080, 0, 32'hA000, "win_rd80");
        host_xfer(1'b0, 16'h008F, 0, 32'hA00F, "win_rd8f");
        host_xfer(1'b0, 16'h0085, 0, 32'hBEEF, "win_rd85");

        // ---- partial window plus edges just outside ----
        core_start = 1'b1;
        tick();
        core_start = 1'b0;
        @(negedge clk);
        chk("part_rv_clr", 32'(results_valid), 0);
        chk("part_cnt_clr", 32'(result_count), 0);
        tick();
        for (int i = 0; i < 17; i++) begin
            mem_we         = 1'b1;
            mem_addr       = (i < 15) ? 16'h0080 + 16'(i) : ((i == 15) ? 16'h007F : 16'h0090);
            mem_write_data = 32'hC000 + 32'(i);
            tick();
        end
        mem_we    = 1'b0;
        core_done = 1'b1;
        tick();
        core_done = 1'b0;
        @(negedge clk);
        chk("part_cnt", 32'(result_count), 15);
        chk("part_rv", 32'(results_valid), 0);
        tick();
        host_xfer(1'b0, 16'h0090, 0, 32'hC010, "part_rd90");

        // ---- core_start while a response is held ----
        host_issue(1'b0, 16'h0010, 0, 32'h1010, "hold_rd");
        host_wait("hold_rd", 2);
        tick();
        core_start     = 1'b1;
        mem_we         = 1'b1;
        mem_addr       = 16'h0010;
        mem_write_data = 32'hDEAD;
        tick();
        core_start = 1'b0;
        mem_we     = 1'b0;
        @(negedge clk);
        chk("hold_vld", 32'(host_rsp_valid), 1);
        chk("hold_data", host_rsp_data, 32'h1010);
        tick();
        core_done = 1'b1;
        tick();
        core_done = 1'b0;
        host_pop("hold_rd");
        host_xfer(1'b0, 16'h0010, 0, 32'hDEAD, "hold_rd2");

        // ---- reset while active with a response pending ----
        host_issue(1'b0, 16'h0001, 0, 32'h1001, "rst_rd");
        host_wait("rst_rd", 2);
        tick();
        core_start = 1'b1;
        mem_addr   = 16'h0003;
        tick();
        core_start = 1'b0;
        reset_n    = 1'b0;
        #1;
        chk_all_zero("midrst");
        exp_q.delete();
        tick();
        reset_n  = 1'b1;
        mem_addr = 16'h0000;
        tick();
        host_xfer(1'b0, 16'h0000, 0, 32'h1000, "post_rst_rd0");
        host_xfer(1'b0, 16'h0100, 0, 32'h0, "oor_host_rd");
        host_xfer(1'b1, 16'h0100, 32'h7777, 0, "oor_host_wr");
        host_xfer(1'b0, 16'h0000, 0, 32'h1000, "oor_alias0");
`ifndef HASH_MEM_OOR_TRAP_EN
        chk("oor_off", 32'(oor_err), 0);
`else
        // ---- out-of-range trap ----
        core_start = 1'b1;
        tick();
        core_start = 1'b0;
        @(negedge clk);
        chk("oor_clr", 32'(oor_err), 0);
        tick();
        mem_we         = 1'b1;
        mem_addr       = 16'h0100;
        mem_write_data = 32'h5555;
        tick();
        mem_we    = 1'b0;
        mem_addr  = 16'h0000;
        core_done = 1'b1;
        tick();
        core_done = 1'b0;
        @(negedge clk);
        chk("oor_set", 32'(oor_err), 1);
        tick();
        host_xfer(1'b0, 16'h0000, 0, 32'h1000, "oor_core_alias0");
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
